// File: rtl/div_pkg.sv
// Shared constants and state encoding for the restoring divider.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CW    = $clog2(DIV_WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_e;

endpackage

// File: rtl/div_acc.sv
// R:Q accumulator for the restoring divider: 2*WIDTH shift register with
// the WIDTH+1 bit trial subtractor. Load seeds R:Q = {0, din}; Sh shifts one
// quotient bit in per clock; Sub lets a non-negative trial replace R.
module div_acc
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             Load,
  input  logic             Sh,
  input  logic             Sub,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem,
  output logic [WIDTH-1:0] quo
);

  logic [WIDTH:0] r_sh;
  logic [WIDTH:0] trial;

  // R shifted left with the next dividend bit, and the trial difference.
  assign r_sh  = {rem, quo[WIDTH-1]};
  assign trial = r_sh - {1'b0, divisor};

  // Load seeds the register; each shift commits the trial or restores R.
  always_ff @(posedge Clk) begin
    if (reset) begin
      rem <= '0;
      quo <= '0;
    end else if (Load) begin
      rem <= '0;
      quo <= din;
    end else if (Sh) begin
      if (Sub && !trial[WIDTH]) begin
        rem <= trial[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b1};
      end else begin
        rem <= r_sh[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/div_restoring.sv
// Sequential restoring divider (DIV/DIVU). One quotient bit per clock,
// results registered with a one-cycle done pulse.
// Optional feature macro: DIV_SIGNED_EN adds the is_signed port, signed
// magnitude handling and a FIX cycle for sign correction.
module div_restoring
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
`ifdef DIV_SIGNED_EN
  ,
  input  logic             is_signed
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_e     state, nxt;
  logic [CW-1:0]  count;
  logic [WIDTH-1:0] dvd_r, dvs_r;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH-1:0] acc_r, acc_q;
  logic           acc_load, acc_sh;
  logic           accept, dvs_zero, sgn_run;

  // A start landing in the done cycle is dropped; IDLE accepts the cycle after.
  assign accept   = (state == IDLE) && start && !done;
  assign dvs_zero = (dvs_r == '0);

`ifdef DIV_SIGNED_EN
  logic sgn_r;
  logic neg_q, neg_r;
  assign sgn_run = sgn_r;
  assign neg_q   = sgn_r && (dvd_r[WIDTH-1] ^ dvs_r[WIDTH-1]);
  assign neg_r   = sgn_r && dvd_r[WIDTH-1];
`else
  assign sgn_run = 1'b0;
`endif

  // Magnitudes fed to the accumulator; plain operands for unsigned runs.
  assign dvd_mag = (sgn_run && dvd_r[WIDTH-1]) ? -dvd_r : dvd_r;
  assign dvs_mag = (sgn_run && dvs_r[WIDTH-1]) ? -dvs_r : dvs_r;

  div_acc #(.WIDTH(WIDTH)) u_acc (
    .Clk     (Clk),
    .reset   (reset),
    .Load    (acc_load),
    .Sh      (acc_sh),
    .Sub     (acc_sh),
    .din     (dvd_mag),
    .divisor (dvs_mag),
    .rem     (acc_r),
    .quo     (acc_q)
  );

  // State register.
  always_ff @(posedge Clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  // Next-state and accumulator controls.
  always_comb begin
    nxt      = state;
    acc_load = 1'b0;
    acc_sh   = 1'b0;
    case (state)
      IDLE: if (accept) nxt = LOAD;
      LOAD: begin
        acc_load = 1'b1;
        nxt      = dvs_zero ? DONE : ITER;
      end
      ITER: begin
        acc_sh = 1'b1;
        if (count == CW'(1)) nxt = sgn_run ? FIX : DONE;
      end
`ifdef DIV_SIGNED_EN
      FIX:  nxt = DONE;
`endif
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Operand capture, iteration counter and registered results/flags.
  always_ff @(posedge Clk) begin
    if (reset) begin
      count     <= '0;
      dvd_r     <= '0;
      dvs_r     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIV_SIGNED_EN
      sgn_r     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (accept) begin
        dvd_r    <= dividend;
        dvs_r    <= divisor;
        div_zero <= 1'b0;
        busy     <= 1'b1;
`ifdef DIV_SIGNED_EN
        sgn_r    <= is_signed;
`endif
      end
      case (state)
        LOAD: count <= CW'(WIDTH);
        ITER: count <= count - 1'b1;
`ifdef DIV_SIGNED_EN
        FIX: begin
          quotient  <= neg_q ? -acc_q : acc_q;
          remainder <= neg_r ? -acc_r : acc_r;
        end
`endif
        DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
          if (dvs_zero) begin
            quotient  <= '1;
            remainder <= dvd_r;
            div_zero  <= 1'b1;
          end else if (!sgn_run) begin
            quotient  <= acc_q;
            remainder <= acc_r;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
